// File: rtl/launchpad_vis_pkg.sv
// Shared types for the bar-level visualizer: level nibbles, meter FSM states,
// and the packing of per-voice levels into the 32-bit sound_data word.
package launchpad_vis_pkg;

  localparam int NUM_BARS = 8;
  localparam int LEVEL_W  = 4;
  localparam int WORD_W   = NUM_BARS * LEVEL_W;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef level_t level_arr_t [NUM_BARS];

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } meter_state_e;

  // Voice 0 lands in the most significant nibble (leftmost bar).
  function automatic logic [WORD_W-1:0] pack_levels(input level_arr_t lv);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int v = 0; v < NUM_BARS; v++) begin
      w[(NUM_BARS-1-v)*LEVEL_W +: LEVEL_W] = lv[v];
    end
    return w;
  endfunction

endpackage

// File: rtl/level_quantizer.sv
// Sample magnitude (saturating abs) and peak-to-level quantization.
// LEVEL_METER_LOG_SCALE_EN selects leading-one (log) levels instead of linear top bits.
module level_quantizer
  import launchpad_vis_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic signed [SAMPLE_W-1:0] sample_data,
  output logic        [SAMPLE_W-2:0] mag,
  input  logic        [SAMPLE_W-2:0] peak,
  output level_t                     level
);

  // The most-negative code has no positive twin, so it clips to full scale.
  function automatic logic [SAMPLE_W-2:0] sat_abs(input logic signed [SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W-1:0] neg;
    neg = -s;
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) return '1;
    if (s[SAMPLE_W-1]) return neg[SAMPLE_W-2:0];
    return s[SAMPLE_W-2:0];
  endfunction

  function automatic level_t quant(input logic [SAMPLE_W-2:0] m);
`ifdef LEVEL_METER_LOG_SCALE_EN
    level_t lv;
    lv = '0;
    for (int b = 0; b < SAMPLE_W-1; b++) begin
      if (m[b]) lv = (b + 1 > 15) ? 4'd15 : 4'(b + 1);
    end
    return lv;
`else
    return m[SAMPLE_W-2 -: LEVEL_W];
`endif
  endfunction

  assign mag   = sat_abs(sample_data);
  assign level = quant(peak);

endmodule

// File: rtl/level_meter.sv
// Per-voice peak meter: tracks peaks between frame ticks, then scans the eight
// voices into decaying 4-bit bar levels and publishes them as one packed word.
// Build option LEVEL_METER_LOG_SCALE_EN (in level_quantizer) selects log levels.
module level_meter
  import launchpad_vis_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int DECAY_STEP   = 1,
  parameter int DECAY_FRAMES = 4
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       frame_tick,
  input  logic                       sample_valid,
  input  logic [2:0]                 sample_ch,
  input  logic signed [SAMPLE_W-1:0] sample_data,
  output logic [WORD_W-1:0]          sound_data,
  output logic                       sound_data_valid,
  output logic                       busy
);

  localparam int         MAG_W      = SAMPLE_W - 1;
  localparam level_t     STEP_L     = level_t'(DECAY_STEP);
  localparam logic [3:0] DECAY_LAST = 4'(DECAY_FRAMES - 1);

  typedef logic [MAG_W-1:0] mag_arr_t [NUM_BARS];

  function automatic level_t sat_dec(input level_t d);
    return (d > STEP_L) ? level_t'(d - STEP_L) : '0;
  endfunction

  function automatic level_t max_lvl(input level_t a, input level_t b);
    return (a > b) ? a : b;
  endfunction

  meter_state_e     state, state_nxt;
  logic [2:0]       idx;
  logic [3:0]       decay_cnt;
  logic             decay_due;
  mag_arr_t         peak, peak_nxt;
  level_arr_t       disp;
  logic [MAG_W-1:0] mag;
  level_t           q_lvl;
  logic             scan_en, publish, tick_acc;

  level_quantizer #(.SAMPLE_W(SAMPLE_W)) u_quant (
    .sample_data (sample_data),
    .mag         (mag),
    .peak        (peak[idx]),
    .level       (q_lvl)
  );

  assign busy = (state == SCAN);

  always_comb begin
    state_nxt = state;
    scan_en   = 1'b0;
    publish   = 1'b0;
    tick_acc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_tick) begin
          state_nxt = SCAN;
          tick_acc  = 1'b1;
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (idx == 3'(NUM_BARS-1)) state_nxt = DONE;
      end
      DONE: begin
        publish   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear-then-accumulate: a sample landing on the voice being scanned seeds the next frame.
  always_comb begin
    for (int i = 0; i < NUM_BARS; i++) begin
      peak_nxt[i] = (scan_en && idx == 3'(i)) ? '0 : peak[i];
      if (sample_valid && sample_ch == 3'(i) && mag > peak_nxt[i]) peak_nxt[i] = mag;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state            <= IDLE;
      idx              <= '0;
      decay_cnt        <= '0;
      decay_due        <= 1'b0;
      sound_data_valid <= 1'b0;
    end else begin
      state            <= state_nxt;
      sound_data_valid <= publish;
      if (tick_acc) begin
        idx <= '0;
        if (decay_cnt == DECAY_LAST) begin
          decay_cnt <= '0;
          decay_due <= 1'b1;
        end else begin
          decay_cnt <= decay_cnt + 4'd1;
          decay_due <= 1'b0;
        end
      end else if (scan_en) begin
        idx <= idx + 3'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sound_data <= '0;
      for (int i = 0; i < NUM_BARS; i++) begin
        peak[i] <= '0;
        disp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BARS; i++) peak[i] <= peak_nxt[i];
      if (scan_en) disp[idx] <= max_lvl(q_lvl, decay_due ? sat_dec(disp[idx]) : disp[idx]);
      if (publish) sound_data <= pack_levels(disp);
    end
  end

endmodule
